div_ctrl: RTL and testbench

Multi-cycle divide sequencer beside the EX stage. It accepts a divide request from EX and runs a 32-step restoring shift-subtract datapath, one step per cycle. While the result is pending it stalls the pipeline. It then returns {remainder, quotient} for the HI/LO write. It also handles divide-by-zero, annulment by pipeline flush, and result hold until EX releases the request.

---
 rtl/div_ctrl_pkg.sv | 36 +++
 rtl/div_ctrl_if.sv | 24 ++
 rtl/div_step.sv | 25 ++
 rtl/div_ctrl.sv | 128 ++++++++++++
 tb/tb_div_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
package div_ctrl_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 6;

   typedef logic [DATA_W-1:0] reg_bus_t;
   typedef logic [CNT_W-1:0]  div_cnt_t;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'b00,
      DIV_DIVZERO = 2'b01,
      DIV_BUSY    = 2'b10,
      DIV_DONE    = 2'b11
   } div_state_e;

   // HI/LO write payload: remainder in the upper half, quotient in the lower
   typedef struct packed {
      reg_bus_t rem;
      reg_bus_t quo;
   } div_result_t;

   localparam logic DIV_START     = 1'b1;
   localparam logic DIV_STOP      = 1'b0;
   localparam logic DIV_READY     = 1'b1;
   localparam logic DIV_NOT_READY = 1'b0;

   function automatic reg_bus_t neg(input reg_bus_t x);
      return reg_bus_t'(~x + reg_bus_t'(1));
   endfunction

   function automatic reg_bus_t abs_val(input reg_bus_t x);
      return x[DATA_W-1] ? neg(x) : x;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EX-side request / result bundle of the divide sequencer.
interface div_ctrl_if;
   import div_ctrl_pkg::*;

   logic        start_i;
   logic        annul_i;
   logic        signed_i;
   reg_bus_t    opdata1_i;
   reg_bus_t    opdata2_i;
   div_result_t result_o;
   logic        ready_o;
   logic        stall_o;

   modport master (
      output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, stall_o
   );

   modport slave (
      input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
      output result_o, ready_o, stall_o
   );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on {rem, dividend}; quotient bits shift into the dividend LSB.
module div_step
   import div_ctrl_pkg::*;
(
   input  reg_bus_t rem_i,
   input  reg_bus_t dvd_i,
   input  reg_bus_t divisor_i,
   output reg_bus_t rem_o,
   output reg_bus_t dvd_o
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;
   logic            take;

   // rem_i < divisor always holds, so diff fits DATA_W bits and its top bit is the borrow
   always_comb begin
      shifted = {rem_i, dvd_i[DATA_W-1]};
      diff    = shifted - {1'b0, divisor_i};
      take    = ~diff[DATA_W];
      rem_o   = take ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      dvd_o   = {dvd_i[DATA_W-2:0], take};
   end

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer: FSM, step counter, operand latch and sign fixup around div_step.
// Signed DIV support is compiled in with `define DIV_SIGNED_EN.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input logic       clk,
   input logic       rst,
   div_ctrl_if.slave bus
);

   div_state_e  state;
   div_cnt_t    cnt;
   reg_bus_t    dvd;
   reg_bus_t    dsr;
   reg_bus_t    rem;
   div_result_t result;
   logic        ready;
   logic        neg_quo;
   logic        neg_rem;

   reg_bus_t    step_rem;
   reg_bus_t    step_dvd;
   reg_bus_t    opa;
   reg_bus_t    opb;
   logic        neg_quo_d;
   logic        neg_rem_d;
   div_result_t final_res;

   div_step u_step (
      .rem_i     (rem),
      .dvd_i     (dvd),
      .divisor_i (dsr),
      .rem_o     (step_rem),
      .dvd_o     (step_dvd)
   );

`ifdef DIV_SIGNED_EN
   // Signed requests run on magnitudes; the signs are restored on the last step
   always_comb begin
      opa       = bus.signed_i ? abs_val(bus.opdata1_i) : bus.opdata1_i;
      opb       = bus.signed_i ? abs_val(bus.opdata2_i) : bus.opdata2_i;
      neg_quo_d = bus.signed_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
      neg_rem_d = bus.signed_i & bus.opdata1_i[DATA_W-1];
   end
`else
   logic unused_signed;
   assign unused_signed = bus.signed_i;
   assign opa       = bus.opdata1_i;
   assign opb       = bus.opdata2_i;
   assign neg_quo_d = 1'b0;
   assign neg_rem_d = 1'b0;
`endif

   always_comb begin
      final_res.quo = neg_quo ? neg(step_dvd) : step_dvd;
      final_res.rem = neg_rem ? neg(step_rem) : step_rem;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DIV_IDLE;
         cnt     <= '0;
         dvd     <= '0;
         dsr     <= '0;
         rem     <= '0;
         result  <= '0;
         ready   <= DIV_NOT_READY;
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (!bus.annul_i && bus.start_i == DIV_START) begin
                  if (bus.opdata2_i == '0) begin
                     state <= DIV_DIVZERO;
                  end else begin
                     dvd     <= opa;
                     dsr     <= opb;
                     rem     <= '0;
                     cnt     <= '0;
                     neg_quo <= neg_quo_d;
                     neg_rem <= neg_rem_d;
                     state   <= DIV_BUSY;
                  end
               end
            end
            DIV_DIVZERO: begin
               if (bus.annul_i) begin
                  state <= DIV_IDLE;
               end else begin
                  result <= '0;
                  ready  <= DIV_READY;
                  state  <= DIV_DONE;
               end
            end
            DIV_BUSY: begin
               if (bus.annul_i) begin
                  cnt   <= '0;
                  state <= DIV_IDLE;
               end else begin
                  dvd <= step_dvd;
                  rem <= step_rem;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(DATA_W - 1)) begin
                     result <= final_res;
                     ready  <= DIV_READY;
                     state  <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: begin
               // Result is held until EX drops the request or the pipeline flushes
               if (bus.start_i == DIV_STOP || bus.annul_i) begin
                  result <= '0;
                  ready  <= DIV_NOT_READY;
                  state  <= DIV_IDLE;
               end
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   assign bus.result_o = result;
   assign bus.ready_o  = ready;
   assign bus.stall_o  = bus.start_i & ~ready & ~bus.annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl against a transaction-level divide model.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_ctrl_if bus ();

   div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference divide: {remainder, quotient}, zero divisor gives zero
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
      longint sa;
      longint sb;
      if (b == 32'd0) return 64'd0;
      if (SIGNED_EN && s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return {32'(sa % sb), 32'(sa / sb)};
      end
      return {a % b, a / b};
   endfunction

   // Model: m_wait counts cycles until the result shows, m_hold while it is presented
   int unsigned m_wait = 0;
   bit          m_hold = 1'b0;
   logic [63:0] m_res  = 64'd0;
   logic [63:0] m_pend = 64'd0;

   initial begin
      forever begin
         @(negedge clk);
         chk("ready", 64'(bus.ready_o), 64'(m_hold));
         chk("result", bus.result_o, m_hold ? m_res : 64'd0);
         chk("stall", 64'(bus.stall_o), 64'(bus.start_i & ~m_hold & ~bus.annul_i));
         if (rst) begin
            m_wait = 0;
            m_hold = 1'b0;
            m_res  = 64'd0;
         end else if (m_hold) begin
            if (!bus.start_i || bus.annul_i) begin
               m_hold = 1'b0;
               m_res  = 64'd0;
            end
         end else if (m_wait != 0) begin
            if (bus.annul_i) begin
               m_wait = 0;
            end else begin
               m_wait--;
               if (m_wait == 0) begin
                  m_hold = 1'b1;
                  m_res  = m_pend;
               end
            end
         end else if (bus.start_i && !bus.annul_i) begin
            m_pend = ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_i);
            m_wait = (bus.opdata2_i == 32'd0) ? 1 : DATA_W;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed divide with literal latency/result checks, hold, and release
   task automatic dir_op(input string nm, input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int lat, input logic [63:0] exp, input int hold);
      bit win_ok = 1'b1;
      bit stable = 1'b1;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      bus.signed_i  = s;
      bus.start_i   = 1'b1;
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         if (c < lat) begin
            if (bus.stall_o !== 1'b1 || bus.ready_o !== 1'b0) win_ok = 1'b0;
            tick();
            if (c == 2) begin
               bus.opdata1_i = $urandom;
               bus.opdata2_i = $urandom | 32'd1;
            end
         end
      end
      chk({nm, "_stall_window"}, 64'(win_ok), 64'd1);
      chk({nm, "_ready"}, 64'(bus.ready_o), 64'd1);
      chk({nm, "_result"}, bus.result_o, exp);
      chk({nm, "_stall_done"}, 64'(bus.stall_o), 64'd0);
      for (int h = 0; h < hold; h++) begin
         tick();
         @(negedge clk);
         if (bus.ready_o !== 1'b1 || bus.result_o !== exp) stable = 1'b0;
      end
      if (hold > 0) chk({nm, "_hold_stable"}, 64'(stable), 64'd1);
      tick();
      bus.start_i = 1'b0;
      tick();
      @(negedge clk);
      chk({nm, "_release"}, {bus.result_o, 63'(0), bus.ready_o}, 64'd0);
      tick();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      bit          got;
      bit          never_ready;
      int          mode;
      int          k;

      rst           = 1'b1;
      bus.start_i   = 1'b0;
      bus.annul_i   = 1'b0;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = '0;
      bus.opdata2_i = '0;

      chk("model_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
      chk("model_div0", ref_div(32'd55, 32'd0, 1'b1), 64'd0);
      chk("model_neg7_2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1),
          SIGNED_EN ? {32'hFFFFFFFF, 32'hFFFFFFFD} : {32'h1, 32'h7FFFFFFC});

      tick();
      @(negedge clk);
      chk("reset_outputs", {bus.result_o, 61'(0), bus.ready_o, bus.stall_o, 1'b0}, 64'd0);
      tick();
      rst = 1'b0;
      tick();

      dir_op("u100_7", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 3);
      dir_op("umax_1", 32'hFFFFFFFF, 32'd1, 1'b0, 33, {32'h0, 32'hFFFFFFFF}, 0);
      dir_op("u5_9", 32'd5, 32'd9, 1'b0, 33, {32'd5, 32'd0}, 1);
      dir_op("divzero", 32'd1234, 32'd0, 1'b0, 2, 64'd0, 0);
      dir_op("s_neg7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 33,
             SIGNED_EN ? {32'hFFFFFFFF, 32'hFFFFFFFD} : {32'h1, 32'h7FFFFFFC}, 0);

      // Flush in cycle 10 of an operation
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.signed_i  = 1'b0;
      bus.start_i   = 1'b1;
      repeat (10) tick();
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      chk("annul_stall", 64'(bus.stall_o), 64'd0);
      tick();
      bus.annul_i = 1'b0;
      never_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.ready_o !== 1'b0) never_ready = 1'b0;
         tick();
      end
      chk("annul_no_ready", 64'(never_ready), 64'd1);
      dir_op("after_annul", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 0);

      // Reset in cycle 5 of an operation
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.start_i   = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst         = 1'b0;
      bus.start_i = 1'b0;
      @(negedge clk);
      chk("rst_mid_outputs", {bus.result_o, 62'(0), bus.ready_o, bus.stall_o}, 64'd0);
      tick();
      dir_op("after_rst", 32'd5, 32'd9, 1'b0, 33, {32'd5, 32'd0}, 0);

      for (int i = 0; i < 60; i++) begin
         a    = $urandom;
         mode = $urandom_range(0, 7);
         b    = (mode == 0) ? 32'd0 : (mode < 3) ? 32'($urandom_range(1, 15)) : $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 100));
         if ($urandom_range(0, 3) == 0) b = -b;
         s    = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 5);
         bus.opdata1_i = a;
         bus.opdata2_i = b;
         bus.signed_i  = s;
         bus.start_i   = 1'b1;
         if (mode == 0) begin
            k = $urandom_range(1, 34);
            repeat (k) tick();
            bus.annul_i = 1'b1;
            bus.start_i = 1'b0;
            tick();
            bus.annul_i = 1'b0;
            tick();
         end else begin
            got = 1'b0;
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               if (bus.ready_o === 1'b1) begin
                  got = 1'b1;
                  break;
               end
               tick();
            end
            chk("rand_timeout", 64'(got), 64'd1);
            repeat ($urandom_range(0, 3)) tick();
            tick();
            if (mode == 1) begin
               bus.annul_i = 1'b1;
               tick();
               bus.annul_i = 1'b0;
            end
            bus.start_i = 1'b0;
            tick();
         end
         bus.opdata1_i = $urandom;
         bus.opdata2_i = $urandom;
         tick();
      end

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
